rca_config_sequencer: RTL
=========================

RCA_CONFIG_SEQUENCER -- requirements
Module: rca_config_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_RCAS  4  number of reconfigurable accelerators
- NUM_READ_PORTS  5  source-address slots per RCA
- NUM_WRITE_PORTS  5  destination-address slots per RCA
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  config request valid
- req_ready  out  1  sequencer can accept a request
- req_rca  in  clog2(NUM_RCAS)  target RCA
- req_src_addrs  in  5*NUM_READ_PORTS  packed source reg addrs; slot i in bits [5i+4:5i]
- req_src_mask  in  NUM_READ_PORTS  bit i set = write source slot i
- req_dest_addrs  in  5*NUM_WRITE_PORTS  packed dest reg addrs; slot j in bits [5j+4:5j]
- req_dest_mask  in  NUM_WRITE_PORTS  bit j set = write dest slot j
- cfg_we  out  1  config-register write strobe
- rca_sel_w  out  clog2(NUM_RCAS)  config write target RCA
- src_port_sel  out  clog2(NUM_READ_PORTS)  source slot index
- dest_port_sel  out  clog2(NUM_WRITE_PORTS)  dest slot index
- src_dest_port  out  1  0 = source slot, 1 = dest slot
- reg_addr  out  5  register address being written
- cfg_done  out  1  one-cycle pulse when a request completes
- rca_configured  out  NUM_RCAS  per-RCA "configuration valid" flags
- rca_inval  in  NUM_RCAS  per-RCA invalidate strobe
- issue_valid  in  1  an instruction wants to issue to an RCA
- issue_rca  in  clog2(NUM_RCAS)  RCA targeted by that issue
- issue_stall  out  1  issue must be held

Function
REQ-003 The FSM SHALL have the states IDLE, WR_SRC, WR_DEST and DONE, with a slot index counter idx.
REQ-004 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready at a rising edge.
REQ-005 On a handshake at edge T, the block SHALL latch req_rca, both address vectors and both masks, clear idx to 0, enter WR_SRC, and clear rca_configured[req_rca].
REQ-006 In WR_SRC, for each cycle T+1+i, i = 0..NUM_READ_PORTS-1, the outputs SHALL be: src_dest_port=0, src_port_sel=i, reg_addr=src slot i, rca_sel_w=latched RCA, cfg_we=src_mask[i].
REQ-007 After slot NUM_READ_PORTS-1, the FSM SHALL enter WR_DEST with idx=0.
REQ-008 In WR_DEST, for each cycle T+1+NUM_READ_PORTS+j, the outputs SHALL be: src_dest_port=1, dest_port_sel=j, reg_addr=dest slot j, cfg_we=dest_mask[j].
REQ-009 After slot NUM_WRITE_PORTS-1, the FSM SHALL enter DONE for exactly one cycle; that cycle is T+11 at the default parameters.
REQ-010 Every slot SHALL consume one cycle whether or not its mask bit is set, so latency is independent of the masks; an all-zero mask runs the full sequence with cfg_we never asserted.
REQ-011 In DONE, cfg_done SHALL be 1, rca_configured[latched RCA] SHALL be set at the closing edge, and the FSM SHALL return to IDLE, so req_ready=1 at T+12.
REQ-012 Outside WR_SRC and WR_DEST, cfg_we, rca_sel_w, src_port_sel, dest_port_sel, src_dest_port and reg_addr SHALL all be 0.
REQ-013 A set rca_inval[k] bit SHALL clear rca_configured[k] at the next edge in any state.
REQ-014 If rca_inval[k] coincides with the DONE set for RCA k, the invalidate SHALL win and the bit ends at 0.
REQ-015 rca_inval SHALL NOT abort an in-flight sequence.
REQ-016 issue_stall SHALL be combinational and equal issue_valid & ~rca_configured[issue_rca]; this also stalls an RCA that is mid-reconfiguration, because its flag was cleared at accept.
REQ-017 req_valid while not in IDLE SHALL be ignored, and input changes after the handshake SHALL not affect the in-flight sequence.

Reset
REQ-018 While rst=0 (asynchronous), the block SHALL force: state=IDLE, idx=0, all latched fields=0, rca_configured=0, cfg_done=0, cfg_we=0, all write outputs=0, req_ready=0.
REQ-019 At the first edge after rst deasserts, req_ready SHALL be 1.
REQ-020 A reset asserted mid-sequence SHALL abort the sequence immediately: no further cfg_we, no cfg_done, and the target flag remains 0.

Verification
REQ-021 Full config: req_rca=2, src addrs 1..5, dest addrs 6..10, both masks 5'b11111 -> ten cfg_we pulses at T+1..T+10 with rca_sel_w=2 and the correct slot/addr pairs; cfg_done at T+11; rca_configured=4'b0100 at T+12.
REQ-022 Sparse masks: src_mask=5'b00101, dest_mask=5'b10000 -> cfg_we only at T+1, T+3 and T+10; cfg_done still at T+11.
REQ-023 Issue gating: issue_valid=1, issue_rca=2 before, during and after REQ-021 -> issue_stall = 1, 1, 0 respectively.
REQ-024 Invalidate race: rca_inval=4'b0100 in the DONE cycle of RCA 2 -> rca_configured[2]=0 afterwards; cfg_done still pulses.
REQ-025 Busy rejection: req_valid held during the sequence with different data -> req_ready=0, and the first request's writes are unchanged.
REQ-026 Mid-sequence reset: rst=0 at T+4 -> cfg_we=0 immediately; rca_configured=0; req_ready=1 one edge after release.

Source files
------------

// File: rtl/rca_config_sequencer.sv
// Configuration sequencer: walks an accepted request through every source and
// destination slot of one RCA, one slot per cycle, and tracks per-RCA validity.
module rca_config_sequencer #(
    parameter int unsigned NUM_RCAS        = 4,
    parameter int unsigned NUM_READ_PORTS  = 5,
    parameter int unsigned NUM_WRITE_PORTS = 5,
    localparam int unsigned RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
    localparam int unsigned SRC_W = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1,
    localparam int unsigned DST_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [RCA_W-1:0]             req_rca,
    input  logic [5*NUM_READ_PORTS-1:0]  req_src_addrs,
    input  logic [NUM_READ_PORTS-1:0]    req_src_mask,
    input  logic [5*NUM_WRITE_PORTS-1:0] req_dest_addrs,
    input  logic [NUM_WRITE_PORTS-1:0]   req_dest_mask,
    output logic                         cfg_we,
    output logic [RCA_W-1:0]             rca_sel_w,
    output logic [SRC_W-1:0]             src_port_sel,
    output logic [DST_W-1:0]             dest_port_sel,
    output logic                         src_dest_port,
    output logic [4:0]                   reg_addr,
    output logic                         cfg_done,
    output logic [NUM_RCAS-1:0]          rca_configured,
    input  logic [NUM_RCAS-1:0]          rca_inval,
    input  logic                         issue_valid,
    input  logic [RCA_W-1:0]             issue_rca,
    output logic                         issue_stall
);

    localparam int unsigned IDX_W = (SRC_W > DST_W) ? SRC_W : DST_W;
    localparam logic [IDX_W-1:0] SRC_LAST = IDX_W'(NUM_READ_PORTS - 1);
    localparam logic [IDX_W-1:0] DST_LAST = IDX_W'(NUM_WRITE_PORTS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_SRC  = 2'd1;
    localparam logic [1:0] ST_WR_DEST = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RCA_W-1:0]             rca_q, rca_d;
    logic [5*NUM_READ_PORTS-1:0]  src_addrs_q, src_addrs_d;
    logic [NUM_READ_PORTS-1:0]    src_mask_q, src_mask_d;
    logic [5*NUM_WRITE_PORTS-1:0] dest_addrs_q, dest_addrs_d;
    logic [NUM_WRITE_PORTS-1:0]   dest_mask_q, dest_mask_d;
    logic [NUM_RCAS-1:0]          configured_q, configured_d;
    logic                         rst_done_q, rst_done_d;

    // req_ready stays low until the first edge after reset release.
    assign req_ready = rst_done_q && (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rca_d        = rca_q;
        src_addrs_d  = src_addrs_q;
        src_mask_d   = src_mask_q;
        dest_addrs_d = dest_addrs_q;
        dest_mask_d  = dest_mask_q;
        configured_d = configured_q;
        rst_done_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rca_d        = req_rca;
                    src_addrs_d  = req_src_addrs;
                    src_mask_d   = req_src_mask;
                    dest_addrs_d = req_dest_addrs;
                    dest_mask_d  = req_dest_mask;
                    idx_d        = '0;
                    state_d      = ST_WR_SRC;
                    for (int unsigned k = 0; k < NUM_RCAS; k++) begin
                        if (req_rca == RCA_W'(k)) configured_d[k] = 1'b0;
                    end
                end
            end
            ST_WR_SRC: begin
                if (idx_q == SRC_LAST) begin
                    idx_d   = '0;
                    state_d = ST_WR_DEST;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_WR_DEST: begin
                if (idx_q == DST_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                for (int unsigned k = 0; k < NUM_RCAS; k++) begin
                    if (rca_q == RCA_W'(k)) configured_d[k] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Invalidate is applied last so it overrides a coinciding DONE set.
        configured_d = configured_d & ~rca_inval;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rca_q        <= '0;
            src_addrs_q  <= '0;
            src_mask_q   <= '0;
            dest_addrs_q <= '0;
            dest_mask_q  <= '0;
            configured_q <= '0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rca_q        <= rca_d;
            src_addrs_q  <= src_addrs_d;
            src_mask_q   <= src_mask_d;
            dest_addrs_q <= dest_addrs_d;
            dest_mask_q  <= dest_mask_d;
            configured_q <= configured_d;
            rst_done_q   <= rst_done_d;
        end
    end

    always_comb begin
        cfg_we        = 1'b0;
        rca_sel_w     = '0;
        src_port_sel  = '0;
        dest_port_sel = '0;
        src_dest_port = 1'b0;
        reg_addr      = '0;

        if (state_q == ST_WR_SRC) begin
            rca_sel_w = rca_q;
            for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    src_port_sel = SRC_W'(i);
                    reg_addr     = src_addrs_q[5*i +: 5];
                    cfg_we       = src_mask_q[i];
                end
            end
        end else if (state_q == ST_WR_DEST) begin
            rca_sel_w     = rca_q;
            src_dest_port = 1'b1;
            for (int unsigned j = 0; j < NUM_WRITE_PORTS; j++) begin
                if (idx_q == IDX_W'(j)) begin
                    dest_port_sel = DST_W'(j);
                    reg_addr      = dest_addrs_q[5*j +: 5];
                    cfg_we        = dest_mask_q[j];
                end
            end
        end
    end

    assign cfg_done       = (state_q == ST_DONE);
    assign rca_configured = configured_q;

    always_comb begin
        issue_stall = 1'b0;
        for (int unsigned k = 0; k < NUM_RCAS; k++) begin
            if (issue_rca == RCA_W'(k)) issue_stall = issue_valid & ~configured_q[k];
        end
    end

endmodule
